latch_shift_chain: RTL

//  Serialises a parallel word into a daisy-chain of CHAINS cascaded latching shift registers (74HC595-style),

---
 rtl/latch_shift_chain_pkg.sv | 22 ++
 rtl/latch_shift_chain_if.sv | 24 ++
 rtl/latch_shift_chain_serialiser.sv | 54 +++++
 rtl/latch_shift_chain.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/latch_shift_chain_pkg.sv
// Shared definitions for the cascaded latching shift-register driver:
// FSM state encoding and the transfer-length helper.
package latch_shift_pkg;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO_ENC = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI_ENC = 2'd2;
  localparam logic [1:0] ST_LATCH_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_SHIFT_LO = ST_SHIFT_LO_ENC,
    ST_SHIFT_HI = ST_SHIFT_HI_ENC,
    ST_LATCH    = ST_LATCH_ENC
  } state_t;

  // Bits per transfer for a chain of 'chains' devices of 'width' bits each.
  function automatic int TOTAL_BITS(input int width, input int chains);
    return width * chains;
  endfunction

endpackage

// File: rtl/latch_shift_chain_if.sv
// Request/serial bundle between a requester (master) and the chain driver (slave).
interface latch_shift_chain_if #(
  parameter int TOTAL = 16
);
  logic             i_clk_stb;
  logic             i_start_stb;
  logic [TOTAL-1:0] i_parallel_data;
  logic             o_busy;
  logic             o_pending;
  logic             o_done_stb;
  logic             o_serial_data;
  logic             o_serial_clk;
  logic             o_serial_latch;

  modport master (
    output i_clk_stb, i_start_stb, i_parallel_data,
    input  o_busy, o_pending, o_done_stb, o_serial_data, o_serial_clk, o_serial_latch
  );

  modport slave (
    input  i_clk_stb, i_start_stb, i_parallel_data,
    output o_busy, o_pending, o_done_stb, o_serial_data, o_serial_clk, o_serial_latch
  );
endinterface

// File: rtl/latch_shift_chain_serialiser.sv
// Load/shift register with bit-order selection and a remaining-bit down-counter.
// The word is stored already advanced by one bit: the first bit is handed to
// the caller combinationally at load time, so the register's top bit is always
// the next bit to present after a shift.
module shift_serialiser #(
  parameter int TOTAL     = 16,
  parameter int MSB_FIRST = 1,
  parameter int CW        = $clog2(TOTAL)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [TOTAL-1:0] i_load_data,
  output logic             o_load_head,
  output logic             o_next_bit,
  output logic             o_cnt_zero
);

  logic [TOTAL-1:0] w_ordered;
  logic [TOTAL-1:0] r_shift;
  logic [CW-1:0]    r_count;

  // Reorder so the internal register always shifts towards its top bit.
  genvar gi;
  generate
    for (gi = 0; gi < TOTAL; gi++) begin : g_order
      if (MSB_FIRST != 0) begin : g_msb
        assign w_ordered[gi] = i_load_data[gi];
      end else begin : g_lsb
        assign w_ordered[gi] = i_load_data[TOTAL-1-gi];
      end
    end
  endgenerate

  assign o_load_head = w_ordered[TOTAL-1];
  assign o_next_bit  = r_shift[TOTAL-1];
  assign o_cnt_zero  = (r_count == '0);

  // Shift register and counter: load presets TOTAL-1 remaining bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shift <= {w_ordered[TOTAL-2:0], 1'b0};
      r_count <= CW'(TOTAL - 1);
    end else if (i_shift) begin
      r_shift <= {r_shift[TOTAL-2:0], 1'b0};
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/latch_shift_chain.sv
// Drives a daisy-chain of 74HC595-style latching shift registers: shifts a
// TOTAL-bit word out one half-bit per pacing strobe, then pulses the latch.
// A one-entry pending buffer holds the newest request made while busy.
module latch_shift_chain
  import latch_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHAINS    = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  latch_shift_chain_if.slave bus
);

  localparam int TOTAL = TOTAL_BITS(WIDTH, CHAINS);

  state_t           r_state, w_state_next;
  logic             r_busy, w_busy_next;
  logic             r_pend, w_pend_next;
  logic [TOTAL-1:0] r_pbuf, w_pbuf_next;
  logic             r_done, w_done_next;
  logic             r_data, w_data_next;
  logic             r_sclk, w_sclk_next;
  logic             r_latch, w_latch_next;

  logic             w_load;
  logic             w_shift;
  logic [TOTAL-1:0] w_load_data;
  logic             w_load_head;
  logic             w_next_bit;
  logic             w_cnt_zero;

  shift_serialiser #(
    .TOTAL     (TOTAL),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_load_data (w_load_data),
    .o_load_head (w_load_head),
    .o_next_bit  (w_next_bit),
    .o_cnt_zero  (w_cnt_zero)
  );

  // Next-state, pending-buffer and registered-output logic.
  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_pbuf_next  = r_pbuf;
    w_done_next  = 1'b0;
    w_data_next  = r_data;
    w_sclk_next  = r_sclk;
    w_latch_next = r_latch;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_load_data  = bus.i_parallel_data;

    // Requests while busy land in the buffer; latest one wins.
    if (bus.i_start_stb && (r_state != ST_IDLE)) begin
      w_pend_next = 1'b1;
      w_pbuf_next = bus.i_parallel_data;
    end

    case (r_state)
      ST_IDLE: begin
        w_data_next  = 1'b0;
        w_sclk_next  = 1'b0;
        w_latch_next = 1'b0;
        if (bus.i_start_stb) begin
          w_load       = 1'b1;
          w_data_next  = w_load_head;
          w_state_next = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (bus.i_clk_stb) begin
          w_sclk_next  = 1'b1;
          w_state_next = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (bus.i_clk_stb) begin
          w_sclk_next = 1'b0;
          if (!w_cnt_zero) begin
            w_shift      = 1'b1;
            w_data_next  = w_next_bit;
            w_state_next = ST_SHIFT_LO;
          end else begin
            w_latch_next = 1'b1;
            w_data_next  = 1'b0;
            w_state_next = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (bus.i_clk_stb) begin
          w_latch_next = 1'b0;
          w_done_next  = 1'b1;
          // A start on this very strobe bypasses and discards the buffer.
          if (bus.i_start_stb || r_pend) begin
            w_load       = 1'b1;
            w_load_data  = bus.i_start_stb ? bus.i_parallel_data : r_pbuf;
            w_pend_next  = 1'b0;
            w_data_next  = w_load_head;
            w_sclk_next  = 1'b0;
            w_state_next = ST_SHIFT_LO;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  // State and output registers; reset aborts any transfer silently.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_pbuf  <= '0;
      r_done  <= 1'b0;
      r_data  <= 1'b0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= w_busy_next;
      r_pend  <= w_pend_next;
      r_pbuf  <= w_pbuf_next;
      r_done  <= w_done_next;
      r_data  <= w_data_next;
      r_sclk  <= w_sclk_next;
      r_latch <= w_latch_next;
    end
  end

  assign bus.o_busy         = r_busy;
  assign bus.o_pending      = r_pend;
  assign bus.o_done_stb     = r_done;
  assign bus.o_serial_data  = r_data;
  assign bus.o_serial_clk   = r_sclk;
  assign bus.o_serial_latch = r_latch;

endmodule
